// File: rtl/slc3_mem_arbiter.sv
// Two-port arbiter and strobe sequencer for the shared asynchronous SRAM.
// Port 0 is the CPU, port 1 is the program loader/debug port. A single grant
// is active at a time; reads take RD1/RD2, writes take WR1/WR2/WR3, and every
// access ends in a one-cycle ACK followed by an IDLE cycle.
// Build option: define SLC3_MEMARB_FIXED_PRIO_EN to make port 0 always win a
// simultaneous request (default build is round-robin).
module slc3_mem_arbiter #(
    parameter int unsigned AW = 20,
    parameter int unsigned DW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          req0_i,
    input  logic          req1_i,
    input  logic          we0_i,
    input  logic          we1_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic [DW-1:0] wdata1_i,
    output logic          ack0_o,
    output logic          ack1_o,
    output logic [DW-1:0] rdata_o,
    output logic          busy_o,
    output logic          Mem_CE_o,
    output logic          Mem_UB_o,
    output logic          Mem_LB_o,
    output logic          Mem_OE_o,
    output logic          Mem_WE_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [DW-1:0] sram_dq_out_o,
    output logic          sram_dq_oe_o,
    input  logic [DW-1:0] sram_dq_in_i
);

    typedef enum logic [2:0] {
        StIdle,
        StRd1,
        StRd2,
        StWr1,
        StWr2,
        StWr3,
        StAck
    } state_e;

    state_e        state_q, state_d;
    logic          grant_q, grant_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          pick;
    logic          pick_we;

`ifdef SLC3_MEMARB_FIXED_PRIO_EN
    // CPU always wins when both ports request.
    always_comb begin
        pick = ~req0_i;
    end
`else
    logic last_grant_q, last_grant_d;

    // Round-robin: on a tie the port not granted last wins.
    always_comb begin
        if (req0_i && req1_i) begin
            pick = ~last_grant_q;
        end else begin
            pick = req1_i;
        end
    end

    // Remember the last granted port; reset favours the CPU on the first tie.
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == StIdle && (req0_i || req1_i)) begin
            last_grant_d = pick;
        end
    end

    // Round-robin history register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign pick_we = pick ? we1_i : we0_i;

    // Next-state logic: capture the winning request in IDLE, then sequence strobes.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req0_i || req1_i) begin
                    grant_d = pick;
                    addr_d  = pick ? addr1_i : addr0_i;
                    wdata_d = pick ? wdata1_i : wdata0_i;
                    state_d = pick_we ? StWr1 : StRd1;
                end
            end
            StRd1: state_d = StRd2;
            StRd2: begin
                rdata_d = sram_dq_in_i;
                state_d = StAck;
            end
            StWr1: state_d = StWr2;
            StWr2: state_d = StWr3;
            StWr3: state_d = StAck;
            StAck: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and captured-request registers; reset aborts any access in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            grant_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Output decode from registered state only; strobes are active low.
    always_comb begin
        Mem_CE_o     = 1'b1;
        Mem_UB_o     = 1'b1;
        Mem_LB_o     = 1'b1;
        Mem_OE_o     = 1'b1;
        Mem_WE_o     = 1'b1;
        sram_dq_oe_o = 1'b0;
        ack0_o       = 1'b0;
        ack1_o       = 1'b0;
        unique case (state_q)
            StRd1, StRd2: begin
                Mem_CE_o = 1'b0;
                Mem_UB_o = 1'b0;
                Mem_LB_o = 1'b0;
                Mem_OE_o = 1'b0;
            end
            StWr1, StWr3: begin
                Mem_CE_o     = 1'b0;
                Mem_UB_o     = 1'b0;
                Mem_LB_o     = 1'b0;
                sram_dq_oe_o = 1'b1;
            end
            StWr2: begin
                Mem_CE_o     = 1'b0;
                Mem_UB_o     = 1'b0;
                Mem_LB_o     = 1'b0;
                Mem_WE_o     = 1'b0;
                sram_dq_oe_o = 1'b1;
            end
            StAck: begin
                ack0_o = ~grant_q;
                ack1_o = grant_q;
            end
            default: ;
        endcase
    end

    assign busy_o        = (state_q != StIdle);
    assign rdata_o       = rdata_q;
    assign sram_addr_o   = addr_q;
    assign sram_dq_out_o = wdata_q;

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Scoreboard bench for slc3_mem_arbiter: directed reads/writes, contention,
// reset abort, then a random sequential run with protocol checks every cycle.
module tb_slc3_mem_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req0, req1, we0, we1;
    logic [19:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1, busy;
    logic [15:0] rdata;
    logic        ce, ub, lb, oe, we;
    logic [19:0] sram_addr;
    logic [15:0] dq_out, dq_in;
    logic        dq_oe;

    typedef struct packed {
        logic        port;
        logic        rd;
        logic [19:0] addr;
        logic [15:0] data;
    } item_t;

    item_t       sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        tb_last;
    logic [15:0] shadow [1024];
    logic [15:0] sram [1024];
    logic        sram_init = 1'b0;

    always #5 Clk = ~Clk;

    slc3_mem_arbiter dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .req0_i       (req0),
        .req1_i       (req1),
        .we0_i        (we0),
        .we1_i        (we1),
        .addr0_i      (addr0),
        .addr1_i      (addr1),
        .wdata0_i     (wdata0),
        .wdata1_i     (wdata1),
        .ack0_o       (ack0),
        .ack1_o       (ack1),
        .rdata_o      (rdata),
        .busy_o       (busy),
        .Mem_CE_o     (ce),
        .Mem_UB_o     (ub),
        .Mem_LB_o     (lb),
        .Mem_OE_o     (oe),
        .Mem_WE_o     (we),
        .sram_addr_o  (sram_addr),
        .sram_dq_out_o(dq_out),
        .sram_dq_oe_o (dq_oe),
        .sram_dq_in_i (dq_in)
    );

    function automatic logic [15:0] init_val(input int i);
        if (i == 'h12) return 16'h1234;
        return 16'(i * 16'h0131) ^ 16'h5A5A;
    endfunction

    // SRAM model: reads while CE/OE low, writes at the clock while WE low.
    always_comb dq_in = (!ce && !oe) ? sram[sram_addr[9:0]] : 16'hDEAD;
    always @(posedge Clk) begin
        if (!sram_init) begin
            for (int i = 0; i < 1024; i++) sram[i] <= init_val(i);
            sram_init <= 1'b1;
        end else if (!ce && !we && dq_oe) begin
            sram[sram_addr[9:0]] <= dq_out;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: protocol checks each cycle and scoreboard compare on every ack.
    initial begin : monitor
        int          oe_cnt, we_cnt;
        logic [15:0] we_data, last_rd;
        logic [19:0] strobe_addr;
        logic        prev_ack, prev_req0, prev_req1;
        item_t       it;
        oe_cnt = 0; we_cnt = 0; we_data = '0; last_rd = '0; strobe_addr = '0;
        prev_ack = 1'b0; prev_req0 = 1'b0; prev_req1 = 1'b0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                oe_cnt = 0; we_cnt = 0; prev_ack = 1'b0; last_rd = '0;
            end else begin
                check("oe_we_overlap", 32'(!oe && !we), 32'd0);
                check("dq_oe_while_oe", 32'(!oe && dq_oe), 32'd0);
                check("busy_decode", 32'(busy), 32'(!ce || ack0 || ack1));
                check("ack_width", 32'(prev_ack && (ack0 || ack1)), 32'd0);
                check("ack_both", 32'(ack0 && ack1), 32'd0);
                if (!ce) strobe_addr = sram_addr;
                if (!oe) oe_cnt++;
                if (!we) begin
                    we_cnt++;
                    we_data = dq_out;
                end
                if (ack0 || ack1) begin
                    if (sb.size() == 0) begin
                        check("unexpected_ack", 32'd1, 32'd0);
                    end else begin
                        it = sb.pop_front();
                        check("ack_port", 32'(ack1), 32'(it.port));
                        check("ack_after_req", 32'(ack1 ? prev_req1 : prev_req0), 32'd1);
                        check("access_addr", 32'(strobe_addr), 32'(it.addr));
                        check("oe_cycles", 32'(oe_cnt), it.rd ? 32'd2 : 32'd0);
                        check("we_cycles", 32'(we_cnt), it.rd ? 32'd0 : 32'd1);
                        if (it.rd) begin
                            check("rdata", 32'(rdata), 32'(it.data));
                            last_rd = it.data;
                        end else begin
                            check("wr_data", 32'(we_data), 32'(it.data));
                            check("rdata_hold", 32'(rdata), 32'(last_rd));
                        end
                    end
                    oe_cnt = 0;
                    we_cnt = 0;
                end
                prev_ack = ack0 || ack1;
            end
            prev_req0 = req0;
            prev_req1 = req1;
        end
    end

    task automatic push(input logic p, input logic w, input logic [19:0] a, input logic [15:0] d);
        item_t it;
        it.port = p;
        it.rd   = !w;
        it.addr = a;
        it.data = w ? d : shadow[a[9:0]];
        if (w) shadow[a[9:0]] = d;
        sb.push_back(it);
        tb_last = p;
    endtask

    // One access on one port; returns cycles from request to ack.
    task automatic txn(input logic p, input logic w, input logic [19:0] a, input logic [15:0] d,
                       output int lat);
        @(negedge Clk);
        push(p, w, a, d);
        if (p) begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        end
        lat = 0;
        while (1) begin
            @(negedge Clk);
            lat++;
            if (p ? ack1 : ack0) break;
            if (lat >= 20) begin
                check("ack_timeout", 32'd1, 32'd0);
                break;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check(tag, 32'({ce, ub, lb, oe, we, ack0, ack1, busy, dq_oe}), 32'h1F << 4);
    endtask

    initial begin : stim
        int   lat, n, cyc, wait_cyc;
        logic w;
        Reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tb_last = 1'b1;
        for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);

        repeat (3) @(negedge Clk);
        check_idle("reset_ctrl");
        check("reset_addr", 32'(sram_addr), 32'd0);
        check("reset_dq_out", 32'(dq_out), 32'd0);
        check("reset_rdata", 32'(rdata), 32'd0);
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            check_idle("idle_no_req");
        end

        txn(1'b0, 1'b0, 20'h00012, 16'h0000, lat);
        check("rd_latency", 32'(lat), 32'd3);
        txn(1'b1, 1'b1, 20'h00040, 16'hBEEF, lat);
        check("wr_latency", 32'(lat), 32'd4);
        txn(1'b0, 1'b0, 20'h00040, 16'h0000, lat);
        check("rd_back_latency", 32'(lat), 32'd3);

        // Reset during WR2 aborts the write with no ack.
        @(negedge Clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 20'h00080; wdata1 = 16'h5555;
        wait_cyc = 0;
        while (we && wait_cyc < 10) begin
            @(negedge Clk);
            wait_cyc++;
        end
        check("wr2_reached", 32'(we), 32'd0);
        #2 Reset = 1'b1;
        #1 check_idle("reset_abort");
        req1 = 1'b0; we1 = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        tb_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check_idle("after_abort");
        end

        // Both ports hold requests for four grants.
        @(negedge Clk);
        for (int i = 0; i < 4; i++) begin
`ifdef SLC3_MEMARB_FIXED_PRIO_EN
            w = 1'b0;
`else
            w = !tb_last;
`endif
            push(w, 1'b0, w ? 20'h00040 : 20'h00012, 16'h0000);
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00012;
        req1 = 1'b1; we1 = 1'b0; addr1 = 20'h00040;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 60) begin
            @(negedge Clk);
            cyc++;
            if (ack0 || ack1) n++;
        end
        req0 = 1'b0; req1 = 1'b0;
        check("contention_acks", 32'(n), 32'd4);

        txn(1'b0, 1'b0, 20'h00080, 16'h0000, lat);

        for (int i = 0; i < 1500; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge Clk);
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                20'($urandom_range(0, 1023)), 16'($urandom), lat);
        end

        repeat (4) @(negedge Clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/slc3_mem_arbiter.md
# slc3_mem_arbiter

Two-port arbiter and access sequencer for the single shared asynchronous SRAM on the SLC-3 board. It places the CPU's memory interface (port 0: instruction fetch, LDR/STR) and the program loader/debug port (port 1) on one SRAM. It grants one requester at a time and generates the multi-cycle active-low strobe sequence for reads and writes. Each requester gets a single-cycle completion acknowledge.

## Interface
Parameters:
- AW, 20, SRAM address width
- DW, 16, data width

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- req0, req1  in  1  access request, port 0 (CPU) / port 1 (loader)
- we0, we1  in  1  1 = write, 0 = read; qualified by reqN
- addr0, addr1  in  AW  word address
- wdata0, wdata1  in  DW  write data
- ack0, ack1  out  1  one-cycle completion pulse
- rdata  out  DW  read data; shared by both ports; valid in the ack cycle
- busy  out  1  high in every state except IDLE
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1  SRAM strobes, active low
- sram_addr  out  AW  SRAM address
- sram_dq_out  out  DW  data driven to SRAM
- sram_dq_oe  out  1  tristate enable for sram_dq_out
- sram_dq_in  in  DW  data from SRAM

## Operation
- FSM states: IDLE, RD1, RD2, WR1, WR2, WR3, ACK.
- IDLE
  - Samples req0/req1.
  - If any request is present, registers grant, address, we and wdata from the granted port.
  - Goes to RD1 if we=0, or WR1 if we=1.
- RD1: Mem_CE=0, Mem_OE=0, UB=LB=0, sram_addr driven.
- RD2: same strobes; rdata <= sram_dq_in at the end of this cycle.
- WR1: Mem_CE=0, UB=LB=0, Mem_WE=1, sram_dq_oe=1 (address/data setup).
- WR2: as WR1 but Mem_WE=0.
- WR3: as WR1 with Mem_WE=1 (data hold); sram_dq_oe stays 1.
- ACK
  - ackN=1 for the granted port only.
  - All strobes inactive (high); sram_dq_oe=0.
  - Always goes to IDLE next.
- Arbitration (default build is round-robin)
  - If only one port requests, that port wins.
  - If both request, the port not granted last wins.
  - last_grant updates at every grant.
- Requester contract
  - Hold reqN, weN, addrN and wdataN stable until ackN.
  - Drop reqN in the cycle after ackN, or that cycle's IDLE sample counts as a new request.
  - Inputs are ignored outside IDLE.
- rdata holds its value until the next read completes; writes do not alter it.
- Mem_OE and Mem_WE are never low in the same cycle. sram_dq_oe is never 1 while Mem_OE=0.

## Timing
- Reset values
  - Mem_CE=Mem_UB=Mem_LB=Mem_OE=Mem_WE=1.
  - ack0=ack1=0, busy=0, sram_dq_oe=0, sram_addr=0, sram_dq_out=0, rdata=0.
  - State=IDLE.
  - last_grant=port 1, so the CPU wins the first tie.
- Read latency: request sampled at edge E → RD1 at E+1, RD2 at E+2, ACK at E+3. ack asserts 3 cycles after E.
- Write latency: WR1/WR2/WR3 at E+1..E+3, ACK at E+4. ack asserts 4 cycles after E.
- Back-to-back: one mandatory IDLE cycle between ACK and the next access. The minimum period is 4 cycles for a read and 5 for a write.
- Simultaneous requests in IDLE: exactly one grant; the loser waits, with its req held, for the next IDLE.
- Reset asserted mid-access: all strobes deassert asynchronously, no ack is issued, and the aborted access never completes. Requesters must re-request.
- All outputs are registered or decoded from registered state only. There is no combinational path from reqN to the SRAM strobes.

## Configuration
- SLC3_MEMARB_FIXED_PRIO_EN defined: port 0 (CPU) always wins a simultaneous request; last_grant is unused. A continuously requesting CPU may starve port 1 by design.
- Undefined: round-robin as in Operation.

## Test plan
- Reset then idle: all Mem_* = 1, ack0/1 = 0, busy = 0 for 10 cycles with no requests.
- Port 0 read, addr0=0x00012, SRAM model returns 0x1234: Mem_OE=0 for exactly 2 cycles, ack0 one cycle after that, rdata=0x1234 in the ack cycle; ack1 stays 0.
- Port 1 write, addr1=0x00040, wdata1=0xBEEF, then port 0 reads 0x00040: Mem_WE low for exactly 1 cycle with sram_dq_out=0xBEEF; the read returns 0xBEEF.
- req0 and req1 both held high for 4 transactions: grants alternate 0,1,0,1 (round-robin); with SLC3_MEMARB_FIXED_PRIO_EN all 4 go to port 0.
- Reset pulsed during WR2: Mem_WE returns to 1 immediately, no ack, state IDLE after release.
- Protocol assertions over a 10k-cycle random run: never Mem_OE=0 and Mem_WE=0 together; never Mem_OE=0 with sram_dq_oe=1; every ack is one cycle long and follows a request on the same port.
